fifo_wr_arbiter: RTL and testbench

//  Round-robin, burst-locked write arbiter sharing one 8-bit synchronous FIFO among NUM_REQ producers.

---
 rtl/fifo_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 124 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the burst-locked FIFO write arbiter.
// Holds the FSM state type, the default data width and the wrap increment.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DATA_W_DEF = 8;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after i_ptr, wrapping.
// Ports: i_req (request vector), i_ptr (start index), o_found, o_idx.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_off;
  logic [IW:0]   w_sum;

  // Scan offsets high to low so the smallest offset wins.
  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--)
      if (i_req[IW'((int'(i_ptr) + k) % N)])
        w_off = IW'(k);
  end

  assign o_found = |i_req;
  assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx   = (w_sum >= (IW+1)'(N))
                 ? IW'(w_sum - (IW+1)'(N))
                 : w_sum[IW-1:0];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked write arbiter in front of one FIFO write port.
// Ports: clk, rst (sync, active-low); per producer req_valid/req_data/
// req_last/req_ready; FIFO side fifo_full/fifo_wr/fifo_data_in; status
// grant_id, busy, preempt. Define FIFO_ARB_STATS_EN to add stat_beats,
// a saturating 16-bit transfer counter per producer.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int MAX_BURST = 16,
  localparam int IW        = $clog2(NUM_REQ),
  localparam int CW        = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_wr,
  output logic [DATA_W-1:0]           fifo_data_in,
  output logic [IW-1:0]               grant_id,
  output logic                        busy,
  output logic                        preempt
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]       stat_beats
`endif
);

  arb_state_t        r_state;
  logic [IW-1:0]     r_grant;
  logic [IW-1:0]     r_ptr;
  logic [CW-1:0]     r_cnt;

  logic              w_found;
  logic [IW-1:0]     w_pick;
  logic              w_busy;
  logic              w_open;
  logic              w_xfer;
  logic              w_last;
  logic              w_cap;
  logic              w_rel;
  logic [DATA_W-1:0] w_data;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  assign w_busy = (r_state == BURST);
  // Reset gates the write path so nothing lands during the reset cycle.
  assign w_open = rst & w_busy & ~fifo_full;
  assign w_xfer = w_open & req_valid[r_grant];
  assign w_last = req_last[r_grant];
  assign w_data = req_data[int'(r_grant)*DATA_W +: DATA_W];

  // Cap hit when this transfer is beat number MAX_BURST.
  generate
    if (MAX_BURST > 0) begin : g_cap
      assign w_cap = (r_cnt == CW'(MAX_BURST - 1));
    end else begin : g_nocap
      assign w_cap = 1'b0;
    end
  endgenerate

  assign w_rel = w_xfer & (w_last | w_cap);

  assign fifo_wr      = w_xfer;
  assign fifo_data_in = w_busy ? w_data : '0;
  assign req_ready    = w_open ? (NUM_REQ'(1) << r_grant) : '0;
  assign grant_id     = r_grant;
  assign busy         = w_busy;
  assign preempt      = w_xfer & w_cap & ~w_last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_state <= BURST;
          end
        end
        BURST: begin
          if (w_rel) begin
            r_state <= IDLE;
            r_ptr   <= IW'(rr_next(int'(r_grant), NUM_REQ));
            r_cnt   <= '0;
          end else if (w_xfer && MAX_BURST > 0) begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] r_stat [NUM_REQ];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++)
        r_stat[i] <= '0;
    end else if (w_xfer && r_stat[r_grant] != 16'hFFFF) begin
      r_stat[r_grant] <= r_stat[r_grant] + 16'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    assign stat_beats[gi*16 +: 16] = r_stat[gi];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus
// randomized traffic against a behavioural arbitration model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 16;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic [N*DW-1:0] req_data;
  logic          fifo_full;
  logic          fifo_wr;
  logic [DW-1:0] fifo_data_in;
  logic [1:0]    grant_id;
  logic          busy;
  logic          preempt;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] stat_beats;
`endif

  typedef struct packed {
    logic [1:0] id;
    logic       last;
    logic [7:0] d;
  } beat_t;

  beat_t      pq[$];
  int         pcnt[N];
  logic [9:0] wlog[$];
  int         wcyc[$];
  int         pre_at[$];
  logic [N-1:0] gap;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int m_busy  = 0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_beats = 0;
  int m_stat[N];
  int mf;

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr      (fifo_wr),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy),
    .preempt      (preempt)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_beats   (stat_beats)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pop(input int id);
    int k;
    k = 0;
    while (k < pq.size() && int'(pq[k].id) != id) k++;
    if (k < pq.size()) begin
      pq.delete(k);
      pcnt[id]--;
    end
  endtask

  task automatic refresh();
    logic [N-1:0]    v;
    logic [N-1:0]    l;
    logic [N*DW-1:0] d;
    int f;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < N; i++) begin
      f = 0;
      if (pcnt[i] > 0)
        for (int k = 0; k < pq.size() && f == 0; k++)
          if (int'(pq[k].id) == i) begin
            f = 1;
            v[i] = ~gap[i];
            l[i] = pq[k].last;
            d[i*DW +: DW] = pq[k].d;
          end
    end
    req_valid = v;
    req_last  = l;
    req_data  = d;
  endtask

  task automatic push(input int id, input int n, input int d0);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.id   = 2'(id);
      b.last = (k == n - 1);
      b.d    = 8'(d0 + k);
      pq.push_back(b);
    end
    pcnt[id] += n;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    refresh();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fifo_full = 1'b0;
    gap = '0;
    pq.delete();
    foreach (pcnt[i]) pcnt[i] = 0;
    refresh();
    tick();
    rst = 1'b1;
    wlog.delete();
    wcyc.delete();
    pre_at.delete();
  endtask

  task automatic wait_writes(input int n, input int lim);
    int k;
    k = 0;
    while (wlog.size() < n && k < lim) begin
      tick();
      k++;
    end
  endtask

  // Producers, write log and reference model all advance on the clock edge.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) pop(i);
    if (fifo_wr) begin
      wlog.push_back({grant_id, fifo_data_in});
      wcyc.push_back(cyc);
    end
    if (preempt) pre_at.push_back(wlog.size());

    if (!rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
      foreach (m_stat[i]) m_stat[i] = 0;
    end else if (m_busy == 0) begin
      if (req_valid != '0) begin
        mf = 0;
        for (int k = 0; k < N; k++)
          if (mf == 0 && req_valid[(m_ptr + k) % N]) begin
            mf = 1;
            m_owner = (m_ptr + k) % N;
          end
        m_busy = 1;
      end
    end else if (req_valid[m_owner] && !fifo_full) begin
      m_beats++;
      if (m_stat[m_owner] < 65535) m_stat[m_owner]++;
      if (req_last[m_owner] || m_beats == MB) begin
        m_busy = 0;
        m_ptr = (m_owner + 1) % N;
        m_beats = 0;
      end
    end
  end

  always @(negedge clk) begin
    total++;
    if (fifo_wr === 1'b1 && fifo_full === 1'b1) begin
      bad++;
      $display("FAIL fifo_side cycle=%0d wr=1 while full=1, required wr=0", cyc);
    end
  end

  task automatic test_reset();
    logic [9:0] ex[3];
    ex[0] = 10'h004; ex[1] = 10'h005; ex[2] = 10'h330;
    rst = 1'b0; fifo_full = 1'b0; gap = '0;
    pq.delete();
    foreach (pcnt[i]) pcnt[i] = 0;
    refresh();
    tick();
    tick();
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || grant_id !== 2'd0 || fifo_wr !== 1'b0 ||
        req_ready !== 4'd0 || preempt !== 1'b0) begin
      bad++;
      $display("FAIL reset_state busy=%b grant=%0d wr=%b rdy=%b pre=%b, required 0 0 0 0000 0",
               busy, grant_id, fifo_wr, req_ready, preempt);
    end
    tick();
    rst = 1'b1;
    wlog.delete(); wcyc.delete(); pre_at.delete();
    push(2, 1, 8'h20);
    refresh();
    wait_writes(1, 10);
    push(0, 5, 8'h01);
    refresh();
    wait_writes(4, 20);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (fifo_wr !== 1'b0 || req_ready !== 4'd0 || req_valid[0] !== 1'b1) begin
      bad++;
      $display("FAIL reset_gate wr=%b rdy=%b valid0=%b, required wr=0 rdy=0000 valid0=1",
               fifo_wr, req_ready, req_valid[0]);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || grant_id !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid busy=%b grant=%0d, required 0 0", busy, grant_id);
    end
    push(3, 1, 8'h30);
    refresh();
    tick();
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || grant_id !== 2'd0) begin
      bad++;
      $display("FAIL reset_regrant busy=%b grant=%0d, required 1 0", busy, grant_id);
    end
    wait_writes(7, 20);
    total++;
    if (wlog.size() != 7) begin
      bad++;
      $display("FAIL reset_count writes=%0d, required 7", wlog.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (wlog[4 + k] !== ex[k]) begin
          bad++;
          $display("FAIL reset_data[%0d] got=%h required=%h", k, wlog[4 + k], ex[k]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [9:0] ex[5];
    ex[0] = 10'h0A0; ex[1] = 10'h1B0; ex[2] = 10'h2C0;
    ex[3] = 10'h3D0; ex[4] = 10'h0A1;
    do_reset();
    push(0, 1, 8'hA0); push(0, 1, 8'hA1);
    push(1, 1, 8'hB0); push(2, 1, 8'hC0); push(3, 1, 8'hD0);
    refresh();
    wait_writes(5, 30);
    total++;
    if (wlog.size() != 5) begin
      bad++;
      $display("FAIL rr_count writes=%0d, required 5", wlog.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (wlog[k] !== ex[k]) begin
          bad++;
          $display("FAIL rr_order[%0d] got=%h required=%h", k, wlog[k], ex[k]);
        end
      end
      for (int k = 1; k < 5; k++) begin
        total++;
        if (wcyc[k] - wcyc[k-1] != 2) begin
          bad++;
          $display("FAIL rr_spacing[%0d] gap=%0d, required 2", k, wcyc[k] - wcyc[k-1]);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    push(1, 4, 8'h11);
    refresh();
    wait_writes(1, 10);
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (fifo_wr !== 1'b0 || req_ready !== 4'd0 || busy !== 1'b1 || grant_id !== 2'd1) begin
        bad++;
        $display("FAIL stall[%0d] wr=%b rdy=%b busy=%b grant=%0d, required 0 0000 1 1",
                 k, fifo_wr, req_ready, busy, grant_id);
      end
      tick();
    end
    fifo_full = 1'b0;
    wait_writes(4, 20);
    total++;
    if (wlog.size() != 4) begin
      bad++;
      $display("FAIL stall_count writes=%0d, required 4", wlog.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (wlog[k] !== 10'(10'h111 + k)) begin
          bad++;
          $display("FAIL stall_data[%0d] got=%h required=%h", k, wlog[k], 10'(10'h111 + k));
        end
      end
    end
    total++;
    if (pre_at.size() != 0) begin
      bad++;
      $display("FAIL stall_preempt count=%0d, required 0", pre_at.size());
    end
  endtask

  task automatic test_preempt();
    logic [9:0] e;
    do_reset();
    push(2, 20, 8'h40);
    push(3, 2, 8'h60);
    refresh();
    wait_writes(22, 80);
    total++;
    if (wlog.size() != 22) begin
      bad++;
      $display("FAIL pre_count writes=%0d, required 22", wlog.size());
    end else begin
      for (int k = 0; k < 22; k++) begin
        if (k < 16)      e = 10'h240 + 10'(k);
        else if (k < 18) e = 10'h360 + 10'(k - 16);
        else             e = 10'h250 + 10'(k - 18);
        total++;
        if (wlog[k] !== e) begin
          bad++;
          $display("FAIL pre_order[%0d] got=%h required=%h", k, wlog[k], e);
        end
      end
    end
    total++;
    if (pre_at.size() != 1 || pre_at[0] != 16) begin
      bad++;
      $display("FAIL pre_pulse count=%0d at=%0d, required 1 at 16",
               pre_at.size(), (pre_at.size() > 0) ? pre_at[0] : -1);
    end
  endtask

  task automatic test_last16();
    logic [9:0] e;
    do_reset();
    push(0, 16, 8'h80);
    push(1, 1, 8'h70);
    push(0, 1, 8'h90);
    refresh();
    wait_writes(18, 60);
    total++;
    if (wlog.size() != 18) begin
      bad++;
      $display("FAIL last16_count writes=%0d, required 18", wlog.size());
    end else begin
      for (int k = 0; k < 18; k++) begin
        if (k < 16)       e = 10'h080 + 10'(k);
        else if (k == 16) e = 10'h170;
        else              e = 10'h090;
        total++;
        if (wlog[k] !== e) begin
          bad++;
          $display("FAIL last16_order[%0d] got=%h required=%h", k, wlog[k], e);
        end
      end
    end
    total++;
    if (pre_at.size() != 0) begin
      bad++;
      $display("FAIL last16_preempt count=%0d, required 0", pre_at.size());
    end
  endtask

  task automatic test_random();
    logic         e_wr;
    logic [N-1:0] e_rdy;
    logic [DW-1:0] e_dat;
    logic         e_pre;
    int p;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(5) == 0) begin
        p = int'($urandom_range(N - 1));
        if (pcnt[p] < 40)
          push(p, 1 + int'($urandom_range(19)), int'($urandom_range(255)));
      end
      for (int i = 0; i < N; i++) gap[i] = ($urandom_range(5) == 0);
      fifo_full = ($urandom_range(3) == 0);
      rst = ($urandom_range(79) != 0);
      refresh();
      @(negedge clk);
      e_wr  = rst && m_busy != 0 && req_valid[m_owner] && !fifo_full;
      e_rdy = (rst && m_busy != 0 && !fifo_full) ? N'(1 << m_owner) : '0;
      e_dat = (m_busy != 0) ? req_data[m_owner*DW +: DW] : '0;
      e_pre = e_wr && !req_last[m_owner] && (m_beats == MB - 1);
      total++;
      if (fifo_wr !== e_wr || req_ready !== e_rdy || fifo_data_in !== e_dat ||
          preempt !== e_pre || busy !== (m_busy != 0) || grant_id !== 2'(m_owner)) begin
        bad++;
        $display("FAIL random c=%0d got wr=%b rdy=%b d=%h pre=%b busy=%b g=%0d required wr=%b rdy=%b d=%h pre=%b busy=%0d g=%0d",
                 c, fifo_wr, req_ready, fifo_data_in, preempt, busy, grant_id,
                 e_wr, e_rdy, e_dat, e_pre, m_busy, m_owner);
      end
`ifdef FIFO_ARB_STATS_EN
      for (int i = 0; i < N; i++) begin
        total++;
        if (stat_beats[i*16 +: 16] !== 16'(m_stat[i])) begin
          bad++;
          $display("FAIL random_stat[%0d] got=%h required=%h", i, stat_beats[i*16 +: 16], 16'(m_stat[i]));
        end
      end
`endif
      tick();
    end
    rst = 1'b1;
  endtask

`ifdef FIFO_ARB_STATS_EN
  task automatic test_stats();
    int k;
    do_reset();
    push(0, 70000, 0);
    refresh();
    k = 0;
    while (pq.size() != 0 && k < 80000) begin
      tick();
      k++;
    end
    @(negedge clk);
    total++;
    if (pq.size() != 0) begin
      bad++;
      $display("FAIL stats_drain left=%0d, required 0", pq.size());
    end
    total++;
    if (stat_beats[15:0] !== 16'hFFFF) begin
      bad++;
      $display("FAIL stats_sat got=%h required=ffff", stat_beats[15:0]);
    end
    total++;
    if (stat_beats[N*16-1:16] !== '0) begin
      bad++;
      $display("FAIL stats_others got=%h required=0", stat_beats[N*16-1:16]);
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    fifo_full = 1'b0;
    gap = '0;
    foreach (pcnt[i]) pcnt[i] = 0;
    foreach (m_stat[i]) m_stat[i] = 0;
    refresh();
    test_reset();
    test_round_robin();
    test_full_stall();
    test_preempt();
    test_last16();
    test_random();
`ifdef FIFO_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
